// File: rtl/ram_bank.sv
// ram_bank: byte-enabled 1R1W register-array RAM with a sequential full-array clear
module ram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rvalid,
  output logic                      ready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d, mem_addr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, merged, mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic rvalid_q, rvalid_d, mem_we, last;
  always_comb begin
    merged = mem_q[waddr];
    for (int i = 0; i < NB; i++)
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : mem_q[waddr][8*i +: 8];
    last = &clr_ptr_q;
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    mem_we = 1'b0;
    mem_addr = waddr;
    mem_wdata = merged;
    if (clr) begin
      state_d = CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_addr = clr_ptr_q;
      mem_wdata = '0;
      clr_ptr_d = last ? clr_ptr_q : clr_ptr_q + ADDR_WIDTH'(1);
      state_d = last ? READY : CLEAR;
    end else begin
      mem_we = we && |be;
      rvalid_d = re;
      if (re) rdata_d = (RDW_MODE != 0 && we && waddr == raddr) ? merged : mem_q[raddr];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && mem_we) mem_q[mem_addr] <= mem_wdata;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  assign ready = state_q == READY;
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: random + directed checks of ram_bank (both RDW modes) against a behavioural model
module tb_ram_bank;
  logic clk = 0, rst_n = 0, clr = 0, we = 0, re = 0;
  logic [3:0] be = 0, waddr = 0, raddr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata0, rdata1;
  logic rvalid0, rvalid1, ready0, ready1;
  int checks = 0, errors = 0;
  logic [31:0] m_mem [16];
  int clr_left = 16;
  logic [31:0] e_rd0 = 0, e_rd1 = 0;
  logic e_rv = 0, e_rdy = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .be(be), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .ready(ready0));
  ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .be(be), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .ready(ready1));
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction
  // Model: a clear is simply "16 edges of zeroing still owed"; user traffic only when none owed.
  always @(posedge clk) begin
    logic [31:0] nw;
    nw = merge(m_mem[waddr], wdata, be);
    if (!rst_n) begin
      clr_left = 16; e_rv = 0; e_rd0 = 0; e_rd1 = 0;
    end else if (clr) begin
      clr_left = 16; e_rv = 0;
    end else if (clr_left > 0) begin
      m_mem[16 - clr_left] = 0; clr_left--; e_rv = 0;
    end else begin
      if (re) begin
        e_rd0 = m_mem[raddr];
        e_rd1 = (we && waddr == raddr) ? nw : m_mem[raddr];
      end
      e_rv = re;
      if (we) m_mem[waddr] = nw;
    end
    e_rdy = clr_left == 0;
    #1;
    if (chk_en) begin
      check("ready0", 32'(ready0), 32'(e_rdy));
      check("ready1", 32'(ready1), 32'(e_rdy));
      check("rvalid0", 32'(rvalid0), 32'(e_rv));
      check("rvalid1", 32'(rvalid1), 32'(e_rv));
      check("rdata0", rdata0, e_rd0);
      check("rdata1", rdata1, e_rd1);
    end
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic count_ready(input string name);
    int n = 0;
    while (!ready0 && n < 100) begin tick(); n++; end
    check(name, n, 16);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1; waddr = a; wdata = d; be = b; tick(); we = 0; be = 0;
  endtask
  task automatic rd(input logic [3:0] a);
    re = 1; raddr = a; tick(); re = 0;
  endtask
  initial begin
    tick(); tick();
    chk_en = 1;
    check("reset_rdata", rdata0, 0);
    check("reset_ready", 32'(ready0), 0);
    rst_n = 1;
    count_ready("init_clear_edges");
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check("init_zero", rdata0, 0);
      check("init_rvalid", 32'(rvalid0), 1);
    end
    wr(3, 32'hAABBCCDD, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    check("byte_merge", rdata0, 32'hAA22CC44);
    wr(5, 32'h12345678, 4'b1111);
    we = 1; waddr = 5; wdata = 32'hFFFFFFFF; be = 4'b0011; re = 1; raddr = 5;
    tick(); we = 0; re = 0; be = 0;
    check("rdw_old", rdata0, 32'h12345678);
    check("rdw_new", rdata1, 32'h1234FFFF);
    rd(5);
    check("rdw_after0", rdata0, 32'h1234FFFF);
    check("rdw_after1", rdata1, 32'h1234FFFF);
    wr(7, 32'hDEADBEEF, 4'b1111);
    clr = 1; we = 1; waddr = 7; wdata = 32'h55555555; be = 4'hF; re = 1; raddr = 7;
    tick(); clr = 0; we = 0; re = 0; be = 0;
    check("clr_rvalid", 32'(rvalid0), 0);
    count_ready("clr_edges");
    rd(7);
    check("clr_zero", rdata0, 0);
    clr = 1; tick(); clr = 0;
    repeat (7) tick();
    rst_n = 0; tick(); rst_n = 1;
    count_ready("rst_mid_clear");
    clr = 1; tick(); clr = 0;
    repeat (3) tick();
    clr = 1; tick(); clr = 0;
    count_ready("clr_restart");
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 299) != 0;
      clr = $urandom_range(0, 79) == 0;
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 1) == 1;
      be = 4'($urandom);
      waddr = 4'($urandom);
      raddr = $urandom_range(0, 3) == 0 ? waddr : 4'($urandom);
      wdata = $urandom;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width in bits; SHALL be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-002 Parameter ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter RDW_MODE, default 0: read-during-write result; 0 = old data, 1 = new (merged) data.
REQ-004 One clock and one reset: reset is synchronous and active-low; clk  input  1  sole clock, all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 clr  input  1  request full-array clear.
REQ-007 we  input  1  write enable.
REQ-008 be  input  NB  per-byte write enable; bit i covers wdata[8i+7:8i].
REQ-009 waddr  input  ADDR_WIDTH  write address.
REQ-010 wdata  input  DATA_WIDTH  write data.
REQ-011 re  input  1  read enable.
REQ-012 raddr  input  ADDR_WIDTH  read address.
REQ-013 rdata  output  DATA_WIDTH  registered read data.
REQ-014 rvalid  output  1  rdata updated by a read accepted on the previous edge.
REQ-015 ready  output  1  array available; low during clear.

Function
REQ-016 FSM states CLEAR and READY; ready SHALL be 1 exactly when state is READY.
REQ-017 In CLEAR, each edge SHALL write all-zero to mem[clr_ptr] and increment clr_ptr; on the edge writing entry DEPTH-1, state SHALL become READY.
REQ-018 A clear SHALL take exactly DEPTH edges; ready SHALL be high from the DEPTH-th edge of the clear onward.
REQ-019 In CLEAR, we and re SHALL be ignored: no user write, rvalid = 0, rdata holds.
REQ-020 clr = 1 at an edge in READY: state becomes CLEAR, clr_ptr = 0; we/re that same edge SHALL be ignored (clr has priority).
REQ-021 clr = 1 at an edge in CLEAR: clear SHALL restart with clr_ptr = 0.
REQ-022 Write: in READY with we = 1 and clr = 0, each byte lane i with be[i] = 1 SHALL be written from wdata; lanes with be[i] = 0 SHALL keep prior contents; be = 0 writes nothing.
REQ-023 Read: in READY with re = 1 and clr = 0, rdata SHALL load mem[raddr] at that edge and rvalid SHALL be 1 the following cycle; latency = 1 edge.
REQ-024 Without an accepted read, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-025 Read and write to the same address on the same edge: RDW_MODE = 0 SHALL return pre-write contents; RDW_MODE = 1 SHALL return per-lane wdata for be-set lanes and old contents for the rest.
REQ-026 Read and write to different addresses on the same edge SHALL both complete independently.
REQ-027 Addresses SHALL cover all DEPTH entries without aliasing; clr_ptr SHALL stop at DEPTH-1 and not wrap.

Reset
REQ-028 rst_n = 0 at an edge SHALL set state = CLEAR, clr_ptr = 0, ready = 0, rvalid = 0, rdata = 0, regardless of other inputs.
REQ-029 After rst_n returns high, the full clear of REQ-017/018 SHALL run, so every entry reads 0 once ready = 1.
REQ-030 Reset asserted mid-clear or mid-operation SHALL abort the activity and restart as in REQ-028; no user write on that edge.

Verification (DATA_WIDTH 32, ADDR_WIDTH 4)
REQ-031 Release rst_n; count edges -> ready rises after exactly 16 edges; reading addresses 0..15 returns 0x00000000 with rvalid one cycle after each re.
REQ-032 Write 0xAABBCCDD to addr 3 with be = 4'b1111, then 0x11223344 with be = 4'b0101 -> read addr 3 returns 0xAA22CC44.
REQ-033 Addr 5 = 0x12345678; same edge we (addr 5, wdata 0xFFFFFFFF, be = 4'b0011) and re (addr 5) -> RDW_MODE 0: 0x12345678; RDW_MODE 1: 0x1234FFFF; subsequent read 0x1234FFFF in both modes.
REQ-034 Addr 7 = 0xDEADBEEF; assert clr with we/re on the same edge -> ready 0 for 16 edges, rvalid stays 0, then addr 7 reads 0x00000000.
REQ-035 Assert rst_n = 0 at clear edge 8, and clr again at clear edge 4 of a separate run -> clear restarts; ready rises 16 edges after the restart, never earlier.
